memory_reservation_station: RTL
===============================

# memory_reservation_station

Reservation station for the memory pipe in the out-of-order core. Holds issued loads and stores until both register operands are resolved, snooping the common data bus (CDB) for pending values. Dispatches the oldest operand-complete entry over a valid/ready port to the address calculation stage. Acts as the transmitter of that stage's dispatch handshake.

## Interface
- XLEN, 64, data and address width
- ROB_INDEX_WIDTH, 8, ROB index / operand tag width
- SLOTS, 4, number of entries (>=2)

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- issue_valid  in  1  rename offers an instruction
- issue_ready  out  1  station can accept
- issue_1st_reg / issue_2nd_reg  in  XLEN  operand value (base / store data), meaningful when not busy
- issue_1st_busy / issue_2nd_busy  in  1  operand pending on a ROB tag
- issue_1st_tag / issue_2nd_tag  in  ROB_INDEX_WIDTH  producing ROB index when busy
- issue_address  in  XLEN  sign-extended immediate offset
- issue_ROB_index  in  ROB_INDEX_WIDTH  ROB destination of this instruction
- cdb_valid  in  1  CDB broadcast
- cdb_ROB_index  in  ROB_INDEX_WIDTH  tag of broadcast value
- cdb_value  in  XLEN  broadcast value
- dispatch_valid  out  1  selected entry is operand-complete
- dispatch_ready  in  1  address stage accepts
- dispatch_1st_reg, dispatch_2nd_reg, dispatch_address  out  XLEN  operands and immediate of selected entry
- dispatch_ROB_index  out  ROB_INDEX_WIDTH  ROB index of selected entry
- flush  in  1  ROB flush: discard all entries

## Operation
- Collapsing queue: slot 0 is oldest; occupied slots always contiguous 0..count-1; count is clog2(SLOTS+1) bits.
- Per slot: valid, two value/busy/tag triples, immediate, ROB index.
- Entry is eligible when valid and both busy bits clear (registered state only).
- Select: lowest-numbered eligible slot (oldest-ready-first). dispatch_valid = any eligible; dispatch_* driven combinationally from the selected slot; all dispatch data outputs 0 when dispatch_valid=0.
- Dispatch fires on dispatch_valid && dispatch_ready: selected slot removed, all slots above shift down by one, count decrements.
- issue_ready = (count < SLOTS); does not depend on same-cycle dispatch.
- Issue fires on issue_valid && issue_ready: entry written at position count, or count-1 if a dispatch fires the same cycle.
- CDB snoop, every cycle, every valid slot: busy operand whose tag == cdb_ROB_index gets cdb_value and busy cleared. Applied to the post-shift location of shifted entries.
- Issue bypass: an issuing operand with busy=1 and tag == cdb_ROB_index under cdb_valid is stored with cdb_value and busy=0.
- Both operands of one entry may match the same broadcast; both capture.
- Flush or reset: all valid cleared, count=0. A same-cycle issue is dropped and a dispatch handshake is ignored. Reset dominates; flush has the same effect.

## Timing
- Reset values: issue_ready=1, dispatch_valid=0, dispatch_* = 0.
- Issue-to-dispatch: an entry issued at edge N with operands ready (or bypassed) drives dispatch_valid in cycle N+1.
- CDB-to-dispatch: a broadcast at edge N makes the entry eligible in cycle N+1.
- Holding dispatch_ready=0: dispatch_valid and data stay stable unless an older entry becomes eligible. A newly eligible older entry preempts the younger one, which is permitted.
- Full (count=SLOTS): issue_ready=0 for that cycle even if a dispatch fires; issue_ready=1 the cycle after the dispatch.
- Empty: dispatch_valid=0. Simultaneous issue+dispatch at count=1 leaves count=1.
- No combinational path from dispatch_ready or issue_valid to issue_ready.

## Test plan
- Reset, then issue {1st=0x100, 2nd=0x5, imm=0x8, ROB=3, no busy} -> next cycle dispatch_valid=1, 1st=0x100, addr=0x8, ROB=3; dispatch_ready=1 -> count 0, dispatch_valid=0.
- Issue ROB=1 with 1st busy on tag 7, then ROB=2 ready -> ROB=2 dispatches first. Then CDB {7, 0x2000} -> ROB=1 dispatches next cycle with 1st=0x2000.
- Issue with 2nd busy tag 9 while cdb_valid with tag 9, value 0xABCD -> entry eligible next cycle, dispatch_2nd_reg=0xABCD.
- Fill 4 entries with dispatch_ready=0 -> issue_ready=0. Then dispatch one with issue_valid=1 held -> issue_ready back to 1 the next cycle; ordering preserved (ROB order 1,2,3,4,5 out).
- Three entries, middle one dispatched while a CDB wakes the top entry -> top entry shifts to slot 1 with captured value, then dispatches in order.
- Flush with 3 entries plus a same-cycle issue -> next cycle count=0, dispatch_valid=0, issue_ready=1; the dropped issue never appears.

Source files
------------

// File: rtl/memory_reservation_station.sv
// Memory-pipe reservation station: collapsing queue of loads/stores that wait for
// operands on the CDB and dispatch oldest-ready-first to the address stage.
module memory_reservation_station #(
  parameter int XLEN            = 64,
  parameter int ROB_INDEX_WIDTH = 8,
  parameter int SLOTS           = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [XLEN-1:0]            issue_1st_reg,
  input  logic [XLEN-1:0]            issue_2nd_reg,
  input  logic                       issue_1st_busy,
  input  logic                       issue_2nd_busy,
  input  logic [ROB_INDEX_WIDTH-1:0] issue_1st_tag,
  input  logic [ROB_INDEX_WIDTH-1:0] issue_2nd_tag,
  input  logic [XLEN-1:0]            issue_address,
  input  logic [ROB_INDEX_WIDTH-1:0] issue_ROB_index,
  input  logic                       cdb_valid,
  input  logic [ROB_INDEX_WIDTH-1:0] cdb_ROB_index,
  input  logic [XLEN-1:0]            cdb_value,
  output logic                       dispatch_valid,
  input  logic                       dispatch_ready,
  output logic [XLEN-1:0]            dispatch_1st_reg,
  output logic [XLEN-1:0]            dispatch_2nd_reg,
  output logic [XLEN-1:0]            dispatch_address,
  output logic [ROB_INDEX_WIDTH-1:0] dispatch_ROB_index,
  input  logic                       flush
);

  localparam int CW = $clog2(SLOTS + 1);
  localparam int SW = $clog2(SLOTS);
  localparam logic [CW-1:0] FULL = CW'(SLOTS);

  typedef struct packed {
    logic                       valid;
    logic [XLEN-1:0]            reg1;
    logic                       busy1;
    logic [ROB_INDEX_WIDTH-1:0] tag1;
    logic [XLEN-1:0]            reg2;
    logic                       busy2;
    logic [ROB_INDEX_WIDTH-1:0] tag2;
    logic [XLEN-1:0]            imm;
    logic [ROB_INDEX_WIDTH-1:0] rob;
  } entry_t;

  entry_t          slots_q [SLOTS];
  entry_t          slots_d [SLOTS];
  entry_t          ext     [SLOTS+1];
  entry_t          incoming;
  entry_t          shifted;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   write_pos;
  logic [SLOTS-1:0] eligible;
  logic [SW-1:0]   sel;
  logic            any_eligible;
  logic            dispatch_fire;
  logic            issue_fire;

  assign issue_ready   = (count_q < FULL);
  assign dispatch_fire = any_eligible && dispatch_ready;
  assign issue_fire    = issue_valid && issue_ready;
  assign write_pos     = dispatch_fire ? count_q - CW'(1) : count_q;

  // Oldest-ready-first: scanning downward leaves the lowest eligible slot selected.
  always_comb begin
    sel          = '0;
    any_eligible = 1'b0;
    eligible     = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      eligible[i] = slots_q[i].valid && !slots_q[i].busy1 && !slots_q[i].busy2;
      if (eligible[i]) begin
        sel          = SW'(i);
        any_eligible = 1'b1;
      end
    end
  end

  always_comb begin
    dispatch_valid     = any_eligible;
    dispatch_1st_reg   = '0;
    dispatch_2nd_reg   = '0;
    dispatch_address   = '0;
    dispatch_ROB_index = '0;
    if (any_eligible) begin
      dispatch_1st_reg   = slots_q[sel].reg1;
      dispatch_2nd_reg   = slots_q[sel].reg2;
      dispatch_address   = slots_q[sel].imm;
      dispatch_ROB_index = slots_q[sel].rob;
    end
  end

  // New entry, with operands captured straight off the CDB when it carries the tag.
  always_comb begin
    incoming       = '0;
    incoming.valid = 1'b1;
    incoming.reg1  = issue_1st_reg;
    incoming.busy1 = issue_1st_busy;
    incoming.tag1  = issue_1st_tag;
    incoming.reg2  = issue_2nd_reg;
    incoming.busy2 = issue_2nd_busy;
    incoming.tag2  = issue_2nd_tag;
    incoming.imm   = issue_address;
    incoming.rob   = issue_ROB_index;
    if (cdb_valid && issue_1st_busy && issue_1st_tag == cdb_ROB_index) begin
      incoming.reg1  = cdb_value;
      incoming.busy1 = 1'b0;
    end
    if (cdb_valid && issue_2nd_busy && issue_2nd_tag == cdb_ROB_index) begin
      incoming.reg2  = cdb_value;
      incoming.busy2 = 1'b0;
    end
  end

  // Collapse over the dispatched slot, snoop the CDB at the post-shift position,
  // then drop the issuing entry at the first free position.
  always_comb begin
    shifted = '0;
    for (int i = 0; i < SLOTS; i++) ext[i] = slots_q[i];
    ext[SLOTS] = '0;
    for (int i = 0; i < SLOTS; i++) begin
      shifted = (dispatch_fire && i >= int'(sel)) ? ext[i+1] : ext[i];
      if (cdb_valid && shifted.valid && shifted.busy1 && shifted.tag1 == cdb_ROB_index) begin
        shifted.reg1  = cdb_value;
        shifted.busy1 = 1'b0;
      end
      if (cdb_valid && shifted.valid && shifted.busy2 && shifted.tag2 == cdb_ROB_index) begin
        shifted.reg2  = cdb_value;
        shifted.busy2 = 1'b0;
      end
      slots_d[i] = (issue_fire && CW'(i) == write_pos) ? incoming : shifted;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count_q <= '0;
      for (int i = 0; i < SLOTS; i++) slots_q[i] <= '0;
    end else begin
      count_q <= count_q + CW'(issue_fire) - CW'(dispatch_fire);
      for (int i = 0; i < SLOTS; i++) slots_q[i] <= slots_d[i];
    end
  end

endmodule
